d7s_scan_bcd: RTL and testbench
===============================

Name: d7s_scan_bcd

Overview:
- Parametrised successor to the fixed 3-digit, 7-segment multiplexed display driver.
- Accepts a binary value and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes DIGITS common-driver outputs (digit transistors) and one shared segment bus.
- Adds leading-zero blanking, per-digit decimal points, overflow indication, inter-digit ghost blanking and selectable output polarity.
- Sits between the top-level wrapper's pin mapping and the display.

Parameters:
- DIGITS, 3, number of multiplexed digits (1..8); digit 0 = least significant.
- BIN_W, 8, binary input width (1..27).
- PRESCALE, 1000, clock cycles per digit slot (>= 2).
- BLANK_CYC, 1, cycles at the start of each slot with all digits off (0..PRESCALE-1).
- SEG_ACT_LOW, 0, 1 = seg and dp outputs active-low.
- DIG_ACT_LOW, 0, 1 = dig_en outputs active-low.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- bin_value  input  BIN_W  unsigned value to display
- load  input  1  request conversion of bin_value; accepted only when busy=0
- lz_en  input  1  1 = blank leading zeros (sampled live)
- dp_mask  input  DIGITS  decimal point per digit (sampled live)
- seg  output  7  segments; seg[0]=a .. seg[6]=g
- dp  output  1  decimal point for the active digit
- dig_en  output  DIGITS  one-hot digit drive
- busy  output  1  conversion in progress
- ovf  output  1  displayed value overflowed the DIGITS range

Behaviour:
- Reset (async, rst=1), applied immediately:
  - seg, dp and dig_en all at their inactive levels.
  - busy=0, ovf=0.
  - Display BCD register = 0, digit index = 0, prescaler = 0.
- Conversion:
  - load=1 with busy=0 at a clock edge captures bin_value and sets busy=1.
  - The same edge evaluates overflow as bin_value > 10^DIGITS-1.
  - Then exactly BIN_W shift cycles run: add-3 on any nibble >= 5, then shift left.
  - At the BIN_W-th edge after capture, the display BCD register and ovf update together (atomic) and busy returns to 0.
  - busy is high for exactly BIN_W cycles. Load-edge to display update = BIN_W cycles.
  - load while busy=1 is ignored (no queue).
  - The display keeps showing the previous result during conversion.
  - Reset mid-conversion aborts it; the display register returns to 0.
- Scanner:
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - On wrap, the digit index advances 0,1..DIGITS-1,0.
  - dig_en is asserted one-hot for the current index only while prescaler >= BLANK_CYC; otherwise all digits are off.
  - seg and dp are registered from the current index, valid on the same cycles as dig_en.
  - The scanner runs continuously, independent of busy.
- Decode (active-high before polarity), as seg[6:0]:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles >9 cannot occur; decode them to 00.
- Leading-zero blanking:
  - With lz_en=1, digit k is blanked (seg=00) if all BCD digits >= k are zero, for k >= 1.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - dp is still driven by dp_mask on blanked digits.
- Overflow:
  - With ovf=1, every digit shows seg=40 (g only, "-").
  - Leading-zero blanking is ignored while ovf=1; dp follows dp_mask.
- Polarity: seg and dp are inverted when SEG_ACT_LOW=1; dig_en is inverted when DIG_ACT_LOW=1.
- DIGITS=1: the index stays at 0 and dig_en[0] follows only the blanking window.

Test Plan:
- Reset check: assert rst mid-scan with SEG_ACT_LOW=1 and DIG_ACT_LOW=1 -> seg=7F, dp=1 and dig_en=all ones in the same cycle; busy=0 and ovf=0.
- Conversion latency: BIN_W=8, load bin_value=8'd207 -> busy high exactly 8 cycles; then display BCD=2,0,7. With PRESCALE=4 and BLANK_CYC=1, digit 0 shows seg=07, digit 1 shows 3F, digit 2 shows 5B, each on for 3 of every 4 cycles.
- Leading-zero blanking: load 5, lz_en=1 -> digits 2 and 1 show seg=00 and digit 0 shows 6D. Set lz_en=0 -> digits show 3F,3F,6D. Load 0, lz_en=1 -> digit 0 shows 3F, others 00.
- Overflow: DIGITS=2, BIN_W=8, load 100 -> ovf=1 and both digits show 40. Then load 99 -> ovf=0 and both digits show 6F.
- Load during conversion: load 123, then load 45 two cycles later while busy=1 -> second load ignored and the display shows 1,2,3. A load on the first cycle after busy falls is accepted.
- Scan order and ghosting: PRESCALE=3, BLANK_CYC=1, DIGITS=3 -> dig_en sequence per cycle is 000,001,001,000,010,010,000,100,100, repeating; never more than one bit active; dp follows dp_mask=3'b010 only during digit-1 slots.

Source files
------------

// File: rtl/d7s_scan_bcd.sv
// Multiplexed 7-segment driver: sequential double-dabble binary-to-BCD plus a
// prescaled digit scanner with ghost blanking, leading-zero blanking and overflow dash.
module d7s_scan_bcd #(
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned BIN_W       = 8,
  parameter int unsigned PRESCALE    = 1000,
  parameter int unsigned BLANK_CYC   = 1,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          DIG_ACT_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  bin_value,
  input  logic              load,
  input  logic              lz_en,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] dig_en,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SH_W  = BCD_W + BIN_W;
  localparam int unsigned PRE_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  function automatic logic [31:0] pow10_m1(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  localparam logic [31:0] MAX_VAL = pow10_m1(DIGITS);

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t            state, state_n;
  logic              cap, fin;
  logic [SH_W-1:0]   sh, sh_adj, sh_step;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_pend;
  logic [BCD_W-1:0]  disp;

  // Conversion control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cap     = 1'b0;
    fin     = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          cap     = 1'b1;
          state_n = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt == CNT_W'(BIN_W - 1)) begin
          fin     = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_CONV);

  // One double-dabble step: add 3 to nibbles >= 5, then shift left
  always_comb begin
    sh_adj = sh;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (sh[BIN_W + 4*d +: 4] >= 4'd5)
        sh_adj[BIN_W + 4*d +: 4] = sh[BIN_W + 4*d +: 4] + 4'd3;
    end
    sh_step = {sh_adj[SH_W-2:0], 1'b0};
  end

  // Result and overflow flag publish together on the final shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      ovf      <= 1'b0;
    end else begin
      if (cap) begin
        sh       <= {BCD_W'(0), bin_value};
        cnt      <= '0;
        ovf_pend <= (32'(bin_value) > MAX_VAL);
      end else if (state == S_CONV) begin
        sh  <= sh_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (fin) begin
        disp <= sh_step[SH_W-1 -: BCD_W];
        ovf  <= ovf_pend;
      end
    end
  end

  logic [PRE_W-1:0]  pre, pre_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              on_n, hi_zero;
  logic [DIGITS-1:0] dig_oh;
  logic [3:0]        nib;
  logic [6:0]        seg_raw;
  logic              dp_raw;

  // Next scan position and the segment pattern for it
  always_comb begin
    pre_n = (pre == PRE_W'(PRESCALE - 1)) ? '0 : pre + PRE_W'(1);
    idx_n = idx;
    if (pre == PRE_W'(PRESCALE - 1))
      idx_n = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    on_n    = (BLANK_CYC == 0) || (pre_n >= PRE_W'(BLANK_CYC));
    dig_oh  = DIGITS'(1) << idx_n;
    nib     = 4'(disp >> {idx_n, 2'b00});
    hi_zero = (idx_n != '0) && ((disp >> {idx_n, 2'b00}) == '0);
    dp_raw  = |(dp_mask & dig_oh);
    if (ovf)                     seg_raw = 7'h40;
    else if (lz_en && hi_zero)   seg_raw = 7'h00;
    else                         seg_raw = seg_decode(nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre    <= '0;
      idx    <= '0;
      seg    <= {7{SEG_ACT_LOW}};
      dp     <= SEG_ACT_LOW;
      dig_en <= {DIGITS{DIG_ACT_LOW}};
    end else begin
      pre <= pre_n;
      idx <= idx_n;
      if (on_n) begin
        seg    <= seg_raw ^ {7{SEG_ACT_LOW}};
        dp     <= dp_raw ^ SEG_ACT_LOW;
        dig_en <= dig_oh ^ {DIGITS{DIG_ACT_LOW}};
      end else begin
        seg    <= {7{SEG_ACT_LOW}};
        dp     <= SEG_ACT_LOW;
        dig_en <= {DIGITS{DIG_ACT_LOW}};
      end
    end
  end

endmodule

// File: tb/tb_d7s_scan_bcd.sv
// Scoreboard bench: two instances (3-digit active-high, 2-digit active-low);
// stimulus queues expected displays, a monitor checks them when busy falls.
module tb_d7s_scan_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bin_value = '0;
  logic       load = 1'b0;
  logic       lz_en = 1'b0;
  logic [2:0] dp_mask_a = 3'b010;
  logic [1:0] dp_mask_b = 2'b01;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, busy_a, busy_b, ovf_a, ovf_b;
  logic [2:0] dig_en_a;
  logic [1:0] dig_en_b;

  always #5 clk = ~clk;

  d7s_scan_bcd #(.DIGITS(3), .BIN_W(8), .PRESCALE(4), .BLANK_CYC(1),
                 .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) u_a (
    .clk(clk), .rst(rst), .bin_value(bin_value), .load(load), .lz_en(lz_en),
    .dp_mask(dp_mask_a), .seg(seg_a), .dp(dp_a), .dig_en(dig_en_a),
    .busy(busy_a), .ovf(ovf_a));

  d7s_scan_bcd #(.DIGITS(2), .BIN_W(8), .PRESCALE(3), .BLANK_CYC(1),
                 .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) u_b (
    .clk(clk), .rst(rst), .bin_value(bin_value), .load(load), .lz_en(lz_en),
    .dp_mask(dp_mask_b), .seg(seg_b), .dp(dp_b), .dig_en(dig_en_b),
    .busy(busy_b), .ovf(ovf_b));

  typedef struct {
    logic [7:0]      val;
    logic [2:0][6:0] seg_a;
    logic            ovf_a;
    logic [1:0][6:0] seg_b;
    logic            ovf_b;
    bit              scan;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   sent_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: on each busy fall pop one expectation and check a full scan round
  initial begin
    int         bw;
    bit         prev;
    exp_t       e;
    logic [7:0] obs_a [3];
    logic [7:0] obs_b [2];
    int         on_a [3];
    int         on_b [2];
    bit         multi, dpbad;
    logic [1:0] onb;
    logic [6:0] sb;
    prev = 1'b0;
    bw   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        bw   = 0;
        continue;
      end
      if (busy_a) bw++;
      if (prev && !busy_a) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: conversion finished with nothing expected");
        end else begin
          e = sbq.pop_front();
          chk($sformatf("busy_width v=%0d", e.val), bw, 32'd8);
          chk($sformatf("ovf_a v=%0d", e.val), 32'(ovf_a), 32'(e.ovf_a));
          chk($sformatf("ovf_b v=%0d", e.val), 32'(ovf_b), 32'(e.ovf_b));
          chk($sformatf("busy_b v=%0d", e.val), 32'(busy_b), 32'(busy_a));
          if (e.scan) begin
            for (int k = 0; k < 3; k++) begin obs_a[k] = 8'hFF; on_a[k] = 0; end
            for (int k = 0; k < 2; k++) begin obs_b[k] = 8'hFF; on_b[k] = 0; end
            multi = 1'b0;
            dpbad = 1'b0;
            @(negedge clk);
            repeat (12) begin
              @(negedge clk);
              if ($countones(dig_en_a) > 1) multi = 1'b1;
              for (int k = 0; k < 3; k++) begin
                if (dig_en_a[k] && $countones(dig_en_a) == 1) begin
                  on_a[k]++;
                  if (obs_a[k] == 8'hFF) obs_a[k] = {1'b0, seg_a};
                  else if (obs_a[k] != {1'b0, seg_a}) obs_a[k] = 8'hFE;
                  if (dp_a !== dp_mask_a[k]) dpbad = 1'b1;
                end
              end
              onb = ~dig_en_b;
              sb  = ~seg_b;
              if ($countones(onb) > 1) multi = 1'b1;
              for (int k = 0; k < 2; k++) begin
                if (onb[k] && $countones(onb) == 1) begin
                  on_b[k]++;
                  if (obs_b[k] == 8'hFF) obs_b[k] = {1'b0, sb};
                  else if (obs_b[k] != {1'b0, sb}) obs_b[k] = 8'hFE;
                  if (~dp_b !== dp_mask_b[k]) dpbad = 1'b1;
                end
              end
            end
            for (int k = 0; k < 3; k++) begin
              chk($sformatf("seg_a[%0d] v=%0d", k, e.val), 32'(obs_a[k]), 32'({1'b0, e.seg_a[k]}));
              chk($sformatf("on_a[%0d] v=%0d", k, e.val), on_a[k], 32'd3);
            end
            for (int k = 0; k < 2; k++) begin
              chk($sformatf("seg_b[%0d] v=%0d", k, e.val), 32'(obs_b[k]), 32'({1'b0, e.seg_b[k]}));
              chk($sformatf("on_b[%0d] v=%0d", k, e.val), on_b[k], 32'd4);
            end
            chk($sformatf("multi_digit v=%0d", e.val), 32'(multi), 32'd0);
            chk($sformatf("dp_follow v=%0d", e.val), 32'(dpbad), 32'd0);
          end
          done_cnt++;
        end
        bw = 0;
      end
      prev = busy_a;
    end
  end

  task automatic conv(input logic [7:0] v, input bit lz,
                      input logic [2:0][6:0] sa, input logic oa,
                      input logic [1:0][6:0] sb, input logic ob, input bit scan);
    exp_t e;
    e.val = v; e.seg_a = sa; e.ovf_a = oa; e.seg_b = sb; e.ovf_b = ob; e.scan = scan;
    sbq.push_back(e);
    sent_cnt++;
    lz_en     = lz;
    bin_value = v;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt != sent_cnt && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt != sent_cnt) begin
      checks++;
      errors++;
      $display("FAIL timeout: done=%0d expected %0d", done_cnt, sent_cnt);
      sbq.delete();
      done_cnt = sent_cnt;
    end
  endtask

  initial begin
    int t;
    int pre, idx;
    bit on;
    repeat (3) @(negedge clk);
    chk("init_busy_a", 32'(busy_a), 32'd0);
    chk("init_dig_en_b", 32'(dig_en_b), 32'h3);
    rst = 1'b0;

    // digit order in literals: most significant first
    conv(8'd207, 1'b0, {7'h5B, 7'h3F, 7'h07}, 1'b0, {7'h40, 7'h40}, 1'b1, 1'b1); wait_done();
    conv(8'd5,   1'b1, {7'h00, 7'h00, 7'h6D}, 1'b0, {7'h00, 7'h6D}, 1'b0, 1'b1); wait_done();
    conv(8'd5,   1'b0, {7'h3F, 7'h3F, 7'h6D}, 1'b0, {7'h3F, 7'h6D}, 1'b0, 1'b1); wait_done();
    conv(8'd0,   1'b1, {7'h00, 7'h00, 7'h3F}, 1'b0, {7'h00, 7'h3F}, 1'b0, 1'b1); wait_done();
    conv(8'd100, 1'b1, {7'h06, 7'h3F, 7'h3F}, 1'b0, {7'h40, 7'h40}, 1'b1, 1'b1); wait_done();
    conv(8'd99,  1'b1, {7'h00, 7'h6F, 7'h6F}, 1'b0, {7'h6F, 7'h6F}, 1'b0, 1'b1); wait_done();

    // load while busy must be ignored
    conv(8'd123, 1'b0, {7'h06, 7'h5B, 7'h4F}, 1'b0, {7'h40, 7'h40}, 1'b1, 1'b1);
    @(negedge clk);
    bin_value = 8'd45;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done();

    // load on the first cycle after busy falls is accepted
    conv(8'd45, 1'b0, {7'h3F, 7'h66, 7'h6D}, 1'b0, {7'h66, 7'h6D}, 1'b0, 1'b0);
    t = 0;
    while (busy_a && t < 50) begin @(negedge clk); t++; end
    conv(8'd67,  1'b0, {7'h3F, 7'h7D, 7'h07}, 1'b0, {7'h7D, 7'h07}, 1'b0, 1'b1); wait_done();
    conv(8'd150, 1'b0, {7'h06, 7'h6D, 7'h3F}, 1'b0, {7'h40, 7'h40}, 1'b1, 1'b1); wait_done();

    // asynchronous reset while digit 0 of the active-low instance is lit
    t = 0;
    while (dig_en_b !== 2'b10 && t < 50) begin @(negedge clk); t++; end
    chk("pre_rst_dig_en_b", 32'(dig_en_b), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("rst_seg_b", 32'(seg_b), 32'h7F);
    chk("rst_dp_b", 32'(dp_b), 32'd1);
    chk("rst_dig_en_b", 32'(dig_en_b), 32'h3);
    chk("rst_ovf_b", 32'(ovf_b), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_seg_a", 32'(seg_a), 32'h00);
    chk("rst_dig_en_a", 32'(dig_en_a), 32'h0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    lz_en = 1'b0;
    rst   = 1'b0;

    // scan order, ghost blanking and dp, display cleared to 0 by reset
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      pre = n % 4; idx = (n / 4) % 3; on = (pre >= 1);
      chk($sformatf("scan_dig_a n=%0d", n), 32'(dig_en_a), on ? 32'(1 << idx) : 32'd0);
      chk($sformatf("scan_seg_a n=%0d", n), 32'(seg_a), on ? 32'h3F : 32'h00);
      chk($sformatf("scan_dp_a n=%0d", n), 32'(dp_a), 32'(on && dp_mask_a[idx]));
      pre = n % 3; idx = (n / 3) % 2; on = (pre >= 1);
      chk($sformatf("scan_dig_b n=%0d", n), 32'(dig_en_b), on ? 32'(3 ^ (1 << idx)) : 32'h3);
      chk($sformatf("scan_seg_b n=%0d", n), 32'(seg_b), on ? 32'h40 : 32'h7F);
      chk($sformatf("scan_dp_b n=%0d", n), 32'(dp_b), 32'(!(on && dp_mask_b[idx])));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
